// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-client round-robin arbiter sharing a single-write/single-read regfile,
// with a registered, backpressured read-response channel per client.
module regfile_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rf_write_en,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [ADDR_WIDTH-1:0] rf_read_address,
  input  logic [DATA_WIDTH-1:0] rf_read_data
);
  logic last_grant;
  logic elig0, elig1, gnt0, gnt1;
  // a read is only eligible when its response slot is empty or draining this cycle
  always_comb begin
    elig0 = !reset && req0_valid && (req0_write || !rsp0_valid || rsp0_ready);
    elig1 = !reset && req1_valid && (req1_write || !rsp1_valid || rsp1_ready);
    gnt0 = elig0 && (!elig1 || last_grant);
    gnt1 = elig1 && !gnt0;
    rf_write_en = gnt0 ? req0_write : gnt1 ? req1_write : 1'b0;
    rf_write_address = rf_write_en ? (gnt0 ? req0_addr : req1_addr) : '0;
    rf_write_data = rf_write_en ? (gnt0 ? req0_wdata : req1_wdata) : '0;
    rf_read_address = (gnt0 && !req0_write) ? req0_addr :
                      (gnt1 && !req1_write) ? req1_addr : '0;
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      if (gnt0 || gnt1) last_grant <= gnt1;
      if (gnt0 && !req0_write) begin
        rsp0_valid <= 1'b1;
        rsp0_rdata <= rf_read_data;
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (gnt1 && !req1_write) begin
        rsp1_valid <= 1'b1;
        rsp1_rdata <= rf_read_data;
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed test of regfile_arbiter against a behavioural 4-entry regfile.
module tb_regfile_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_write;
  logic [1:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       rsp0_valid, rsp0_ready;
  logic [7:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_write;
  logic [1:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp1_valid, rsp1_ready;
  logic [7:0] rsp1_rdata;
  logic       rf_write_en;
  logic [1:0] rf_write_address, rf_read_address;
  logic [7:0] rf_write_data, rf_read_data;
  logic [7:0] mem [4];
  int n_cmp = 0;
  int n_bad = 0;
  int cnt0, cnt1;

  always #5 clock = ~clock;

  regfile_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
    .rf_write_en(rf_write_en), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data), .rf_read_address(rf_read_address),
    .rf_read_data(rf_read_data)
  );

  always @(posedge clock) if (rf_write_en) mem[rf_write_address] <= rf_write_data;
  assign rf_read_data = mem[rf_read_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    reset = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd0; req0_wdata = 8'hEE; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 2'd0; req1_wdata = 8'h00; rsp1_ready = 1'b0;
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_wen", rf_write_en, 0);
    tick(); tick();
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_rdata", rsp0_rdata, 0);
    chk("rst_rsp1_rdata", rsp1_rdata, 0);
    chk("rst_no_write", mem[0], 8'h00);
    reset = 1'b0; req0_valid = 1'b0;
    #2;
    chk("idle_ready0", req0_ready, 0);
    chk("idle_ready1", req1_ready, 0);
    chk("idle_wen", rf_write_en, 0);
    tick();
    // client 0 fills the regfile, then reads it back
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'(i); req0_wdata = 8'(8'h10 + i);
      #2;
      chk("wr_ready0", req0_ready, 1);
      chk("wr_wen", rf_write_en, 1);
      chk("wr_addr", rf_write_address, i);
      chk("wr_data", rf_write_data, 8'h10 + i);
      tick();
    end
    req0_write = 1'b0; rsp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_addr = 2'(i);
      #2;
      chk("rd_ready0", req0_ready, 1);
      chk("rd_wen", rf_write_en, 0);
      chk("rd_raddr", rf_read_address, i);
      tick();
      chk("rd_rsp0_valid", rsp0_valid, 1);
      chk("rd_rsp0_rdata", rsp0_rdata, 8'h10 + i);
    end
    req0_valid = 1'b0;
    tick();
    chk("rd_drain", rsp0_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // contention: both write continuously, grants must alternate from client 0
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd0; req0_wdata = 8'hA0;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 2'd1; req1_wdata = 8'hB1;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk("rr_ready0", req0_ready, (k % 2) == 0);
      chk("rr_ready1", req1_ready, (k % 2) == 1);
      chk("rr_waddr", rf_write_address, k % 2);
      cnt0 += int'(req0_ready); cnt1 += int'(req1_ready);
      tick();
    end
    chk("rr_cnt0", cnt0, 4);
    chk("rr_cnt1", cnt1, 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    // client 1 read with response backpressure
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd2; rsp1_ready = 1'b0;
    #2;
    chk("bp_first_grant", req1_ready, 1);
    chk("bp_raddr", rf_read_address, 2);
    tick();
    req1_addr = 2'd0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("bp_ready1", req1_ready, 0);
      chk("bp_valid", rsp1_valid, 1);
      chk("bp_rdata", rsp1_rdata, 8'h12);
      tick();
    end
    rsp1_ready = 1'b1;
    #2;
    chk("bp_drain_grant", req1_ready, 1);
    chk("bp_drain_rdata", rsp1_rdata, 8'h12);
    tick();
    chk("bp_second_valid", rsp1_valid, 1);
    chk("bp_second_rdata", rsp1_rdata, 8'hA0);
    req1_valid = 1'b0;
    tick();
    chk("bp_cleared", rsp1_valid, 0);
    // write then read same address: write wins the tie, read sees new data
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd3; req0_wdata = 8'h55;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd3;
    #2;
    chk("raw_ready0", req0_ready, 1);
    chk("raw_ready1", req1_ready, 0);
    chk("raw_wen", rf_write_en, 1);
    tick();
    req0_valid = 1'b0;
    #2;
    chk("raw_read_grant", req1_ready, 1);
    chk("raw_raddr", rf_read_address, 3);
    tick();
    req1_valid = 1'b0;
    chk("raw_valid", rsp1_valid, 1);
    chk("raw_rdata", rsp1_rdata, 8'h55);
    tick();
    // reset with a pending response and two pending writes
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd1; rsp0_ready = 1'b0;
    tick();
    chk("mr_pending", rsp0_valid, 1);
    chk("mr_pending_data", rsp0_rdata, 8'hB1);
    req0_write = 1'b1; req0_addr = 2'd0; req0_wdata = 8'h77;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 2'd2; req1_wdata = 8'h99;
    reset = 1'b1;
    #2;
    chk("mr_ready0", req0_ready, 0);
    chk("mr_ready1", req1_ready, 0);
    chk("mr_wen", rf_write_en, 0);
    tick();
    chk("mr_rsp0_valid", rsp0_valid, 0);
    chk("mr_rsp0_rdata", rsp0_rdata, 0);
    chk("mr_no_write", mem[0], 8'hA0);
    reset = 1'b0;
    #2;
    chk("mr_tie_ready0", req0_ready, 1);
    chk("mr_tie_ready1", req1_ready, 0);
    chk("mr_tie_waddr", rf_write_address, 0);
    tick();
    req0_valid = 1'b0;
    #2;
    chk("mr_next_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("mr_mem0", mem[0], 8'h77);
    chk("mr_mem2", mem[2], 8'h99);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Two-requester round-robin arbiter that shares the single-write/single-read regfile between two clients. Each client issues read or write commands over a valid/ready handshake. The arbiter drives the regfile's write_en/write_address/write_data/read_address and returns read data on a per-client registered response channel with backpressure. It sits between the client logic and the regfile instance.

Parameters:
ADDR_WIDTH, 2, regfile address width (4 entries)
DATA_WIDTH, 8, regfile data width

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  client 0 command valid
req0_ready  output  1  client 0 command accepted this cycle (grant)
req0_write  input  1  1 = write, 0 = read
req0_addr  input  ADDR_WIDTH  client 0 address
req0_wdata  input  DATA_WIDTH  client 0 write data
rsp0_valid  output  1  client 0 read response valid
rsp0_ready  input  1  client 0 accepts response
rsp0_rdata  output  DATA_WIDTH  client 0 read data
req1_valid, req1_ready, req1_write, req1_addr, req1_wdata  same as client 0, for client 1
rsp1_valid, rsp1_ready, rsp1_rdata  same as client 0, for client 1
rf_write_en  output  1  to regfile write_en
rf_write_address  output  ADDR_WIDTH  to regfile write_address
rf_write_data  output  DATA_WIDTH  to regfile write_data
rf_read_address  output  ADDR_WIDTH  to regfile read_address
rf_read_data  input  DATA_WIDTH  from regfile read_data; combinational from rf_read_address

Behaviour:
- Clock and reset: single clock `clock`; reset is synchronous and active-high, port `reset`.
- Reset, sampled at the rising edge of `clock` while high:
  - rsp0_valid, rsp1_valid, rsp0_rdata and rsp1_rdata clear to 0.
  - Round-robin pointer last_grant is set to 1, so client 0 wins the first tie.
- While reset is high: req*_ready=0, rf_write_en=0, no grants.
- Eligibility of client i:
  - Write: eligible when reqi_valid && reqi_write.
  - Read: eligible when reqi_valid && !reqi_write && (!rspi_valid || rspi_ready). The response slot must be free or be draining this cycle.
- Arbitration:
  - At most one grant per cycle. Grant logic is combinational.
  - Only one client eligible: that client is granted.
  - Both eligible: the client != last_grant is granted.
  - last_grant updates to the granted client only on a grant.
  - reqi_ready = granti, so the handshake completes in the same cycle.
- Regfile drive, combinational from the grant:
  - Granted write: rf_write_en=1, rf_write_address=addr, rf_write_data=wdata. The regfile commits at the end of the grant cycle.
  - Granted read: rf_write_en=0, rf_read_address=addr.
  - No grant: rf_write_en=0, rf_read_address=0, rf_write_address=0, rf_write_data=0.
- Read response:
  - At the end of read grant cycle N, rspi_rdata <= rf_read_data and rspi_valid <= 1. Data is visible in cycle N+1, so latency is 1.
  - rspi_valid and rspi_rdata hold stable until rspi_valid && rspi_ready, then rspi_valid clears.
  - Drain and new grant in the same cycle: valid stays 1 and data updates to the new read (back-to-back reads, one per cycle).
- Writes produce no response.
- Ordering:
  - A write granted in cycle N followed by a read of the same address granted in N+1 or later returns the new data.
  - Read and write to the same address cannot occur in the same cycle, since there is only one grant.
- Non-granted clients must hold valid/write/addr/wdata stable until ready. The arbiter does not check this.
- Reset mid-operation:
  - A pending response is dropped (rsp valid clears) and the pointer returns to 1.
  - A write coincident with the reset cycle is not issued (rf_write_en=0).

Test Plan:
- Reset with both clients idle -> all rsp*_valid=0, rf_write_en=0, req*_ready=0 during reset and 0 afterwards while idle.
- Client 0 writes 0x10,0x11,0x12,0x13 to addresses 0..3 on consecutive cycles -> req0_ready=1 each cycle, rf_write_en=1 with matching address/data each cycle; client 0 then reads addresses 0..3 with rsp0_ready=1 -> rsp0_valid one cycle after each grant, rdata 0x10..0x13.
- Both clients request writes continuously (c0 addr 0 data 0xA0, c1 addr 1 data 0xB1) -> grants alternate 0,1,0,1 starting with client 0; each client gets exactly 50% of grants over 8 cycles.
- Client 1 reads addr 2 (holding 0x12) with rsp1_ready=0 for 3 cycles while issuing a second read -> rsp1_valid=1 with rdata 0x12 stable; req1_ready=0 until rsp1_ready=1; second read granted in that same cycle; its data appears next cycle.
- Client 0 writes 0x55 to addr 3 in cycle N while client 1 reads addr 3 -> client 0 is granted in N and client 1 in N+1; rsp1_rdata=0x55 in N+2.
- Reset asserted while rsp0_valid=1 and both requests are pending -> rsp0_valid=0 after the reset edge; the first post-reset tie grants client 0.
